// File: rtl/auc_ecc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | auc_ecc_pkg : ECC point-op command encodings, RAM map, FSM states   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package auc_ecc_pkg;

   localparam logic [1:0] OP_DBL  = 2'd0;
   localparam logic [1:0] OP_ADD  = 2'd1;
   localparam logic [1:0] OP_LOAD = 2'd2;
   localparam logic [1:0] OP_DONE = 2'd3;

   // Operand RAM map: G at the base, constant one, then scratch temporaries
   localparam int X_G    = 0;
   localparam int Y_G    = 1;
   localparam int ONERAM = 19;
   localparam int TEMP0  = 20;
   localparam int TEMP1  = 21;
   localparam int TEMP2  = 22;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LEAD = 3'd1,
      ST_RUN  = 3'd2,
      ST_ADD  = 3'd3,
      ST_FIN  = 3'd4
   } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/auc_wnaf_addr_map.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | auc_wnaf_addr_map : wNAF digit magnitude -> table point X/Y/Z addr  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module auc_wnaf_addr_map #(
   parameter int WINDOW   = 4,
   parameter int ADDR     = 5,
   parameter int PT_BASE  = 0,
   parameter int ONE_ADDR = 19
) (
   input  logic [WINDOW-2:0] mag,
   output logic [ADDR-1:0]   x,
   output logic [ADDR-1:0]   y,
   output logic [ADDR-1:0]   z
);

   localparam int NPT = 2 ** (WINDOW - 2);

   if (WINDOW < 3 || PT_BASE + 3 * NPT - 1 >= 2 ** ADDR) begin : g_param_err
      $error("auc_wnaf_addr_map: table does not fit in the operand RAM");
   end

   logic [WINDOW-3:0] j;
   logic              unused_lsb;

   // Magnitudes are odd, so the LSB carries no index information
   assign j          = mag[WINDOW-2:1];
   assign unused_lsb = mag[0];

   always_comb begin
      if (j == '0) begin
         // G itself is stored affine: Z comes from the shared constant-one word
         x = ADDR'(PT_BASE);
         y = ADDR'(PT_BASE + 1);
         z = ADDR'(ONE_ADDR);
      end else begin
         x = ADDR'(PT_BASE + 3 * int'(j) - 1);
         y = ADDR'(PT_BASE + 3 * int'(j));
         z = ADDR'(PT_BASE + 3 * int'(j) + 1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/auc_wnaf_cmd_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | auc_wnaf_cmd_sequencer : wNAF digit stream -> LOAD/DBL/ADD/DONE cmds|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module auc_wnaf_cmd_sequencer #(
   parameter int ADDR     = 5,
   parameter int WINDOW   = 4,
   parameter int PT_BASE  = 0,
   parameter int ONE_ADDR = 19,
   parameter int CNT_W    = 9
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic              dig_vld,
   output logic              dig_rdy,
   input  logic              dig_sign,
   input  logic [WINDOW-2:0] dig_mag,
   input  logic              dig_last,
   output logic              cmd_vld,
   input  logic              cmd_rdy,
   output logic [1:0]        cmd_op,
   output logic [ADDR-1:0]   cmd_paddx,
   output logic [ADDR-1:0]   cmd_paddy,
   output logic [ADDR-1:0]   cmd_paddz,
   output logic              cmd_neg,
   output logic              cmd_zero,
   output logic              busy,
   output logic              err_ill,
   output logic [CNT_W-1:0]  dig_cnt
);

   import auc_ecc_pkg::*;

   localparam int MW = WINDOW - 1;

   seq_state_t        state_q, state_d;
   logic              cmd_vld_q, cmd_vld_d;
   logic [1:0]        cmd_op_q, cmd_op_d;
   logic [ADDR-1:0]   cmd_paddx_q, cmd_paddx_d;
   logic [ADDR-1:0]   cmd_paddy_q, cmd_paddy_d;
   logic [ADDR-1:0]   cmd_paddz_q, cmd_paddz_d;
   logic              cmd_neg_q, cmd_neg_d;
   logic              cmd_zero_q, cmd_zero_d;
   logic [MW-1:0]     lat_mag_q, lat_mag_d;
   logic              lat_sign_q, lat_sign_d;
   logic              lat_last_q, lat_last_d;
   logic              err_ill_q, err_ill_d;
   logic [CNT_W-1:0]  dig_cnt_q, dig_cnt_d;

   logic              slot_free;
   logic              dig_acc;
   logic              dig_nz;
   logic              dig_bad;
   logic [MW-1:0]     map_mag;
   logic [ADDR-1:0]   map_x, map_y, map_z;

   assign slot_free = !cmd_vld_q || cmd_rdy;
   assign dig_rdy   = slot_free && (state_q == ST_LEAD || state_q == ST_RUN);
   assign dig_acc   = dig_vld && dig_rdy;
   // Legal nonzero magnitudes are odd; anything else is handled as a zero digit
   assign dig_nz    = dig_mag[0];
   assign dig_bad   = !dig_mag[0] && ((dig_mag != '0) || dig_sign);
   assign map_mag   = (state_q == ST_ADD) ? lat_mag_q : dig_mag;

   auc_wnaf_addr_map #(
      .WINDOW   (WINDOW),
      .ADDR     (ADDR),
      .PT_BASE  (PT_BASE),
      .ONE_ADDR (ONE_ADDR)
   ) u_addr_map (
      .mag (map_mag),
      .x   (map_x),
      .y   (map_y),
      .z   (map_z)
   );

   always_comb begin
      state_d     = state_q;
      cmd_vld_d   = cmd_vld_q && !cmd_rdy;
      cmd_op_d    = cmd_op_q;
      cmd_paddx_d = cmd_paddx_q;
      cmd_paddy_d = cmd_paddy_q;
      cmd_paddz_d = cmd_paddz_q;
      cmd_neg_d   = cmd_neg_q;
      cmd_zero_d  = cmd_zero_q;
      lat_mag_d   = lat_mag_q;
      lat_sign_d  = lat_sign_q;
      lat_last_d  = lat_last_q;
      err_ill_d   = err_ill_q;
      dig_cnt_d   = dig_cnt_q;

      if (dig_acc) begin
         dig_cnt_d = (&dig_cnt_q) ? dig_cnt_q : dig_cnt_q + 1'b1;
         if (dig_bad) err_ill_d = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d   = ST_LEAD;
               err_ill_d = 1'b0;
               dig_cnt_d = '0;
            end
         end
         ST_LEAD: begin
            if (dig_acc) begin
               if (dig_nz) begin
                  cmd_vld_d   = 1'b1;
                  cmd_op_d    = OP_LOAD;
                  cmd_paddx_d = map_x;
                  cmd_paddy_d = map_y;
                  cmd_paddz_d = map_z;
                  cmd_neg_d   = dig_sign;
                  cmd_zero_d  = 1'b0;
                  state_d     = dig_last ? ST_FIN : ST_RUN;
               end else if (dig_last) begin
                  cmd_vld_d   = 1'b1;
                  cmd_op_d    = OP_DONE;
                  cmd_paddx_d = '0;
                  cmd_paddy_d = '0;
                  cmd_paddz_d = '0;
                  cmd_neg_d   = 1'b0;
                  cmd_zero_d  = 1'b1;
                  state_d     = ST_IDLE;
               end
            end
         end
         ST_RUN: begin
            if (dig_acc) begin
               cmd_vld_d   = 1'b1;
               cmd_op_d    = OP_DBL;
               cmd_paddx_d = '0;
               cmd_paddy_d = '0;
               cmd_paddz_d = '0;
               cmd_neg_d   = 1'b0;
               cmd_zero_d  = 1'b0;
               if (dig_nz) begin
                  // The add is deferred a cycle so the doubling goes out first
                  lat_mag_d  = dig_mag;
                  lat_sign_d = dig_sign;
                  lat_last_d = dig_last;
                  state_d    = ST_ADD;
               end else if (dig_last) begin
                  state_d = ST_FIN;
               end
            end
         end
         ST_ADD: begin
            if (slot_free) begin
               cmd_vld_d   = 1'b1;
               cmd_op_d    = OP_ADD;
               cmd_paddx_d = map_x;
               cmd_paddy_d = map_y;
               cmd_paddz_d = map_z;
               cmd_neg_d   = lat_sign_q;
               cmd_zero_d  = 1'b0;
               state_d     = lat_last_q ? ST_FIN : ST_RUN;
            end
         end
         ST_FIN: begin
            if (slot_free) begin
               cmd_vld_d   = 1'b1;
               cmd_op_d    = OP_DONE;
               cmd_paddx_d = '0;
               cmd_paddy_d = '0;
               cmd_paddz_d = '0;
               cmd_neg_d   = 1'b0;
               cmd_zero_d  = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Abort behaves like reset but keeps the status a host may still want to read
      if (abort) begin
         state_d     = ST_IDLE;
         cmd_vld_d   = 1'b0;
         cmd_op_d    = '0;
         cmd_paddx_d = '0;
         cmd_paddy_d = '0;
         cmd_paddz_d = '0;
         cmd_neg_d   = 1'b0;
         cmd_zero_d  = 1'b0;
         lat_mag_d   = '0;
         lat_sign_d  = 1'b0;
         lat_last_d  = 1'b0;
         err_ill_d   = err_ill_q;
         dig_cnt_d   = dig_cnt_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cmd_vld_q   <= 1'b0;
         cmd_op_q    <= '0;
         cmd_paddx_q <= '0;
         cmd_paddy_q <= '0;
         cmd_paddz_q <= '0;
         cmd_neg_q   <= 1'b0;
         cmd_zero_q  <= 1'b0;
         lat_mag_q   <= '0;
         lat_sign_q  <= 1'b0;
         lat_last_q  <= 1'b0;
         err_ill_q   <= 1'b0;
         dig_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         cmd_vld_q   <= cmd_vld_d;
         cmd_op_q    <= cmd_op_d;
         cmd_paddx_q <= cmd_paddx_d;
         cmd_paddy_q <= cmd_paddy_d;
         cmd_paddz_q <= cmd_paddz_d;
         cmd_neg_q   <= cmd_neg_d;
         cmd_zero_q  <= cmd_zero_d;
         lat_mag_q   <= lat_mag_d;
         lat_sign_q  <= lat_sign_d;
         lat_last_q  <= lat_last_d;
         err_ill_q   <= err_ill_d;
         dig_cnt_q   <= dig_cnt_d;
      end
   end

   assign cmd_vld   = cmd_vld_q;
   assign cmd_op    = cmd_op_q;
   assign cmd_paddx = cmd_paddx_q;
   assign cmd_paddy = cmd_paddy_q;
   assign cmd_paddz = cmd_paddz_q;
   assign cmd_neg   = cmd_neg_q;
   assign cmd_zero  = cmd_zero_q;
   assign busy      = (state_q != ST_IDLE);
   assign err_ill   = err_ill_q;
   assign dig_cnt   = dig_cnt_q;

endmodule
`default_nettype wire
